gmii_tx_framer: RTL

- Final transmit stage, directly downstream of mac_tx.
- Wraps each Ethernet frame for the GMII interface:
  - emits 7-byte preamble and SFD;
  - pulls frame bytes (dest MAC through payload) from mac_tx;
  - zero-pads to the minimum length;
  - appends the IEEE 802.3 CRC32 FCS;
  - enforces the inter-frame gap.
- Uses the codebase fs/fd start/done handshake toward its controller.

---
 rtl/gmii_tx_framer_if.sv | 29 ++
 rtl/gmii_tx_framer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_framer_if.sv
// Bus between the frame controller / upstream byte source and the GMII framer.
//
// Handshake: the controller raises fs and holds it until it sees fd. frame_len
// is captured once, on the cycle the framer leaves IDLE. data_req is a one-cycle
// pulse per byte. The upstream source presents the requested byte on data_in
// during the cycle immediately after the pulse; there is no back-pressure.
interface gmii_tx_framer_if;
    logic        fs;
    logic        fd;
    logic [15:0] frame_len;
    logic        data_req;
    logic [7:0]  data_in;
    logic        gmii_txen;
    logic [7:0]  gmii_txd;
    logic        gmii_txer;
    logic        busy;

    // Controller and upstream source side
    modport master (
        output fs, frame_len, data_in,
        input  fd, data_req, gmii_txen, gmii_txd, gmii_txer, busy
    );

    // Framer side
    modport slave (
        input  fs, frame_len, data_in,
        output fd, data_req, gmii_txen, gmii_txd, gmii_txer, busy
    );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble + SFD, frame bytes pulled from upstream,
// zero padding up to MIN_FRAME, CRC32 FCS (LSB first), then the inter-frame gap.
// The GMII outputs and fd are registered, so they trail the state by one cycle.
// data_req and busy are decoded directly from the state.
module gmii_tx_framer #(
    parameter int MIN_FRAME = 60,
    parameter int IFG_LEN   = 12,
    parameter int PRE_LEN   = 7
) (
    input  logic              clk,
    input  logic              rst,
    gmii_tx_framer_if.slave   bus,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_DONE
    } state_t;

    localparam logic [15:0] MIN_W    = 16'(MIN_FRAME);
    localparam logic [15:0] PRE_LAST = 16'(PRE_LEN - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);

    state_t      state, state_nx;
    logic [15:0] len_q, cnt, pad_len;
    logic [31:0] crc, crc_inv;
    logic [7:0]  byte_nx;
    logic        txen_nx, req, crc_en, cnt_clr, latch;

    // Reflected CRC32 (0xEDB88320), one byte per call, bit 0 first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Pad length exists only for short frames, so it never wraps.
    assign pad_len = (len_q < MIN_W) ? (MIN_W - len_q) : 16'd0;
    assign crc_inv = ~crc;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next state, byte to transmit, upstream request and datapath controls
    always_comb begin
        state_nx = state;
        byte_nx  = 8'h00;
        txen_nx  = 1'b0;
        req      = 1'b0;
        crc_en   = 1'b0;
        cnt_clr  = 1'b0;
        latch    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.fs) begin
                    latch    = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = S_PRE;
                end
            end
            S_PRE: begin
                txen_nx = 1'b1;
                byte_nx = 8'h55;
                if (cnt == PRE_LAST) begin
                    cnt_clr  = 1'b1;
                    state_nx = S_SFD;
                end
            end
            S_SFD: begin
                txen_nx = 1'b1;
                byte_nx = 8'hD5;
                cnt_clr = 1'b1;
                if (len_q != 16'd0) begin
                    // First request goes out here so the byte lands in the first DATA cycle
                    req      = 1'b1;
                    state_nx = S_DATA;
                end else if (MIN_FRAME > 0) begin
                    state_nx = S_PAD;
                end else begin
                    state_nx = S_FCS;
                end
            end
            S_DATA: begin
                txen_nx = 1'b1;
                byte_nx = bus.data_in;
                crc_en  = 1'b1;
                if (cnt == len_q - 16'd1) begin
                    cnt_clr  = 1'b1;
                    state_nx = (len_q < MIN_W) ? S_PAD : S_FCS;
                end else begin
                    req = 1'b1;
                end
            end
            S_PAD: begin
                txen_nx = 1'b1;
                crc_en  = 1'b1;
                if (cnt == pad_len - 16'd1) begin
                    cnt_clr  = 1'b1;
                    state_nx = S_FCS;
                end
            end
            S_FCS: begin
                txen_nx = 1'b1;
                case (cnt[1:0])
                    2'd0:    byte_nx = crc_inv[7:0];
                    2'd1:    byte_nx = crc_inv[15:8];
                    2'd2:    byte_nx = crc_inv[23:16];
                    default: byte_nx = crc_inv[31:24];
                endcase
                if (cnt == 16'd3) begin
                    cnt_clr  = 1'b1;
                    state_nx = S_IFG;
                end
            end
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    cnt_clr  = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.fs) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Length capture, per-state byte counter and running CRC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q <= 16'd0;
            cnt   <= 16'd0;
            crc   <= 32'hFFFF_FFFF;
        end else begin
            if (latch) len_q <= bus.frame_len;
            if (cnt_clr) cnt <= 16'd0;
            else if (state != S_IDLE && state != S_DONE) cnt <= cnt + 16'd1;
            if (latch) crc <= 32'hFFFF_FFFF;
            else if (crc_en) crc <= crc_byte(crc, byte_nx);
        end
    end

    // Registered GMII outputs and frame-done flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.gmii_txen <= 1'b0;
            bus.gmii_txd  <= 8'h00;
            bus.gmii_txer <= 1'b0;
            bus.fd        <= 1'b0;
        end else begin
            bus.gmii_txen <= txen_nx;
            bus.gmii_txd  <= byte_nx;
            bus.gmii_txer <= 1'b0;
            bus.fd        <= (state == S_DONE);
        end
    end

    assign bus.data_req = req;
    assign bus.busy     = (state != S_IDLE);
    assign dbg_state    = state;

endmodule
